// File: rtl/clock_pkg.sv
// Shared types and constants for the clock design's push-button debouncer.
package clock_pkg;

    localparam int DBC_CNT_W = 4;
    localparam int RPT_CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } dbc_state_t;

    // Stability counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [DBC_CNT_W-1:0] dbc_sat_inc(input logic [DBC_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Repeat counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [RPT_CNT_W-1:0] rpt_sat_inc(input logic [RPT_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: enable, 100 Hz debounce wave, raw buttons
// in, clean levels and press/release strobes out.
interface button_debouncer_if #(
    parameter int N_BTN = 4
);
    logic             en;
    logic             dbcClkIn;
    logic [N_BTN-1:0] btnIn;
    logic [N_BTN-1:0] btnLevel;
    logic [N_BTN-1:0] btnPress;
    logic [N_BTN-1:0] btnRelease;

    modport master (
        output en, dbcClkIn, btnIn,
        input  btnLevel, btnPress, btnRelease
    );

    modport slave (
        input  en, dbcClkIn, btnIn,
        output btnLevel, btnPress, btnRelease
    );
endinterface

// File: rtl/debounce_channel.sv
// Single-button debouncer: 2-flop synchroniser, stability FSM with saturating
// tick counter, registered level and one-cycle press/release strobes.
// Optional auto-repeat of the press strobe while held: DEBOUNCE_REPEAT_EN.
//
//   state        | meaning
//   -------------+--------------------------------------------------
//   IDLE         | released, accepted level 0
//   PRESS_WAIT   | pressed samples seen, counting toward acceptance
//   PRESSED      | press accepted, level 1 (repeat counter runs)
//   RELEASE_WAIT | released samples seen, level still 1
module debounce_channel
    import clock_pkg::*;
#(
    parameter int STABLE_TICKS = 3,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic clkIn,
    input  logic rst,
    input  logic en,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    if (STABLE_TICKS < 1 || STABLE_TICKS > 15) begin : g_bad_stable
        $error("STABLE_TICKS must be in 1..15");
    end
    if (REPEAT_DELAY < 1 || REPEAT_DELAY > 127 || REPEAT_RATE < 1 || REPEAT_RATE > 127) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_RATE must be in 1..127");
    end

    localparam logic [DBC_CNT_W-1:0] STABLE_CNT = DBC_CNT_W'(STABLE_TICKS);
    localparam logic [DBC_CNT_W-1:0] CNT_ONE    = DBC_CNT_W'(1);
    localparam bit                   ONE_TICK   = (STABLE_TICKS <= 1);
    // Synchroniser resets to the released raw level so reset never looks like a press.
    localparam logic                 IDLE_RAW   = (ACTIVE_LOW != 0);

    dbc_state_t           state_q, state_d;
    logic [DBC_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 pressed_s, adv;
    logic                 accept_press, accept_release;
    logic                 rpt_fire;

    assign pressed_s = sync2_q ^ IDLE_RAW;
    assign adv       = tick & en;
    assign cnt_inc   = dbc_sat_inc(cnt_q);

    // Registers: synchroniser, FSM state, stability counter, outputs.
    always_ff @(posedge clkIn) begin
        if (rst) begin
            sync1_q   <= IDLE_RAW;
            sync2_q   <= IDLE_RAW;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Synchroniser shift path; free-running, only the tick-cycle sample matters.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    // Next-state and counter logic, advancing only on an enabled tick.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        accept_press   = 1'b0;
        accept_release = 1'b0;
        if (adv) begin
            case (state_q)
                IDLE: begin
                    if (pressed_s) begin
                        if (ONE_TICK) begin
                            state_d      = PRESSED;
                            cnt_d        = '0;
                            accept_press = 1'b1;
                        end else begin
                            state_d = PRESS_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc >= STABLE_CNT) begin
                        state_d      = PRESSED;
                        cnt_d        = '0;
                        accept_press = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!pressed_s) begin
                        if (ONE_TICK) begin
                            state_d        = IDLE;
                            cnt_d          = '0;
                            accept_release = 1'b1;
                        end else begin
                            state_d = RELEASE_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_s) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_inc >= STABLE_CNT) begin
                        state_d        = IDLE;
                        cnt_d          = '0;
                        accept_release = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [RPT_CNT_W-1:0] RPT_DELAY_CNT = RPT_CNT_W'(REPEAT_DELAY);
    localparam logic [RPT_CNT_W-1:0] RPT_RATE_CNT  = RPT_CNT_W'(REPEAT_RATE);

    logic [RPT_CNT_W-1:0] rpt_q, rpt_d, rpt_inc;
    logic                 rpt_armed_q, rpt_armed_d;

    assign rpt_inc = rpt_sat_inc(rpt_q);

    // Repeat counter registers; armed selects the shorter inter-repeat period.
    always_ff @(posedge clkIn) begin
        if (rst) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end

    // Repeat counting: clear on a fresh press, run while held, freeze in RELEASE_WAIT.
    always_comb begin
        rpt_d       = rpt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_fire    = 1'b0;
        if (adv) begin
            if (accept_press) begin
                rpt_d       = '0;
                rpt_armed_d = 1'b0;
            end else if (state_q == PRESSED && pressed_s) begin
                if (rpt_inc >= (rpt_armed_q ? RPT_RATE_CNT : RPT_DELAY_CNT)) begin
                    rpt_d       = '0;
                    rpt_armed_d = 1'b1;
                    rpt_fire    = 1'b1;
                end else begin
                    rpt_d = rpt_inc;
                end
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Output decode from the next state so the registered level lines up with the strobes.
    always_comb begin
        level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        press_d   = accept_press | rpt_fire;
        release_d = accept_release;
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer. One shared registered rising-edge
// detector turns the 100 Hz debounce wave into a one-cycle tick enable;
// each button gets its own debounce_channel.
// Optional auto-repeat while held: DEBOUNCE_REPEAT_EN.
module button_debouncer
    import clock_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = 3,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic          clkIn,
    input  logic          rst,
    button_debouncer_if.slave bus
);

    logic             dbc_q, dbc_d;
    logic             tick_q, tick_d;
    logic [N_BTN-1:0] level_w, press_w, release_w;

    // Edge register and registered tick; both hold while disabled.
    always_ff @(posedge clkIn) begin
        if (rst) begin
            dbc_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            dbc_q  <= dbc_d;
            tick_q <= tick_d;
        end
    end

    // Rising edge of the debounce wave, suppressed while disabled.
    always_comb begin
        dbc_d  = bus.en ? bus.dbcClkIn : dbc_q;
        tick_d = bus.en & bus.dbcClkIn & ~dbc_q;
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clkIn       (clkIn),
            .rst         (rst),
            .en          (bus.en),
            .tick        (tick_q),
            .btn_raw     (bus.btnIn[g]),
            .btn_level   (level_w[g]),
            .btn_press   (press_w[g]),
            .btn_release (release_w[g])
        );
    end

    assign bus.btnLevel   = level_w;
    assign bus.btnPress   = press_w;
    assign bus.btnRelease = release_w;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (default parameters, active-low keys).
module tb_button_debouncer;

    localparam int N = 4;

    logic clkIn = 1'b0;
    logic rst   = 1'b1;

    button_debouncer_if #(.N_BTN(N)) bus ();

    button_debouncer #(.N_BTN(N)) dut (
        .clkIn (clkIn),
        .rst   (rst),
        .bus   (bus)
    );

    always #10 clkIn = ~clkIn;

    typedef struct {
        int         due;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } exp_t;

    typedef struct {
        bit         rst;
        bit         en;
        logic [3:0] btn;   // pressed mask (raw input is its inverse)
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[$];
    int         cyc     = 0;
    int         n_pass  = 0;
    int         n_chk   = 0;
    logic [3:0] cur_lvl = '0;
    bit         mon_on  = 0;

    always @(posedge clkIn) cyc <= cyc + 1;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp_v);
    endtask

    // Scoreboard monitor: due entries are compared in full; every other cycle must be strobe-free.
    always @(negedge clkIn) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            n_chk++;
            $display("FAIL sb_order cycle %0d: entry due %0d not consumed", cyc, e.due);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("level", bus.btnLevel, e.lvl);
            check("press", bus.btnPress, e.prs);
            check("release", bus.btnRelease, e.rel);
            cur_lvl = e.lvl;
            mon_on  = 1;
        end else if (mon_on) begin
            check("idle_level", bus.btnLevel, cur_lvl);
            check("idle_press", bus.btnPress, 4'b0000);
            check("idle_release", bus.btnRelease, 4'b0000);
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    // One debounce tick with the given pressed mask; outputs expected two cycles after the wave rises.
    task automatic do_tick(input logic [3:0] btn, input bit en_v,
                           input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
        bus.btnIn = ~btn;
        bus.en    = en_v;
        wait_neg(4);
        bus.dbcClkIn = 1'b1;
        sb.push_back('{due: cyc + 2, lvl: lvl, prs: prs, rel: rel});
        wait_neg(3);
        bus.dbcClkIn = 1'b0;
        wait_neg(3);
    endtask

    task automatic do_reset(input logic [3:0] btn);
        bus.btnIn = ~btn;
        rst = 1'b1;
        sb.push_back('{due: cyc + 1, lvl: 4'b0000, prs: 4'b0000, rel: 4'b0000});
        wait_neg(1);
        rst = 1'b0;
        wait_neg(2);
    endtask

    task automatic tk(input logic [3:0] b, input logic [3:0] l, input logic [3:0] p, input logic [3:0] r);
        vecs.push_back('{rst: 0, en: 1, btn: b, lvl: l, prs: p, rel: r});
    endtask
    task automatic fz(input logic [3:0] b, input logic [3:0] l);
        vecs.push_back('{rst: 0, en: 0, btn: b, lvl: l, prs: 4'b0000, rel: 4'b0000});
    endtask
    task automatic rs(input logic [3:0] b);
        vecs.push_back('{rst: 1, en: 1, btn: b, lvl: 4'b0000, prs: 4'b0000, rel: 4'b0000});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bus.en       = 1'b1;
        bus.dbcClkIn = 1'b0;
        bus.btnIn    = '1;

        // clean press / release on channel 0
        tk(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0001, 4'b0001, 4'b0001, 4'b0000);
        tk(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0000, 4'b0000, 4'b0001);
        tk(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // bounce on channel 1: 2 pressed, 1 released, 3 pressed
        tk(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0010, 4'b0010, 4'b0010, 4'b0000);
        tk(4'b0000, 4'b0010, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0010, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0000, 4'b0000, 4'b0010);
        // reset mid PRESS_WAIT on channel 2
        tk(4'b0100, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0100, 4'b0000, 4'b0000, 4'b0000);
        rs(4'b0100);
        tk(4'b0100, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0100, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0100, 4'b0100, 4'b0100, 4'b0000);
        tk(4'b0000, 4'b0100, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0100, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0000, 4'b0000, 4'b0100);
        // enable freeze after tick 2 on channel 3
        tk(4'b1000, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b1000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) fz(4'b1000, 4'b0000);
        tk(4'b1000, 4'b1000, 4'b1000, 4'b0000);
        tk(4'b0000, 4'b1000, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b1000, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0000, 4'b0000, 4'b1000);
        // all channels together, reset while pressed, re-accept, release together
        tk(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b1111, 4'b1111, 4'b1111, 4'b0000);
        tk(4'b1111, 4'b1111, 4'b0000, 4'b0000);
        rs(4'b1111);
        tk(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b1111, 4'b1111, 4'b1111, 4'b0000);
        tk(4'b0000, 4'b1111, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b1111, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0000, 4'b0000, 4'b1111);
        // release bounce: RELEASE_WAIT returns to PRESSED without strobes
        tk(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tk(4'b0001, 4'b0001, 4'b0001, 4'b0000);
        tk(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        tk(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        tk(4'b0000, 4'b0000, 4'b0000, 4'b0001);

        wait_neg(2);
        do_reset(4'b0000);
        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.rst) do_reset(v.btn);
            else       do_tick(v.btn, v.en, v.lvl, v.prs, v.rel);
        end

        // glitches between ticks are never sampled: one while pressed, one while idle
        do_tick(4'b0010, 1, 4'b0000, 4'b0000, 4'b0000);
        do_tick(4'b0010, 1, 4'b0000, 4'b0000, 4'b0000);
        do_tick(4'b0010, 1, 4'b0010, 4'b0010, 4'b0000);
        bus.btnIn = ~4'b0000;
        wait_neg(3);
        do_tick(4'b0010, 1, 4'b0010, 4'b0000, 4'b0000);
        do_tick(4'b0000, 1, 4'b0010, 4'b0000, 4'b0000);
        do_tick(4'b0000, 1, 4'b0010, 4'b0000, 4'b0000);
        do_tick(4'b0000, 1, 4'b0000, 4'b0000, 4'b0010);
        bus.btnIn = ~4'b0010;
        wait_neg(3);
        for (int i = 0; i < 3; i++) do_tick(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);

`ifdef DEBOUNCE_REPEAT_EN
        // hold channel 0 for 100 ticks: press at tick 3, then 53, 63, 73, 83, 93
        for (int t = 1; t <= 100; t++) begin
            logic [3:0] l, p;
            l = (t >= 3) ? 4'b0001 : 4'b0000;
            p = (t == 3 || (t >= 53 && (t - 53) % 10 == 0)) ? 4'b0001 : 4'b0000;
            do_tick(4'b0001, 1, l, p, 4'b0000);
        end
        do_tick(4'b0000, 1, 4'b0001, 4'b0000, 4'b0000);
        do_tick(4'b0000, 1, 4'b0001, 4'b0000, 4'b0000);
        do_tick(4'b0000, 1, 4'b0000, 4'b0000, 4'b0001);
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) wait_neg(1);
        if (sb.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
